// File: rtl/fast_cmd_pkg.sv
// Fast-command shared definitions: FSM state encoding, frame width and the
// fast-command code points used by the aligner and downstream decoders.
package fast_cmd_pkg;

    localparam int FC_W = 8;

    // Encoding matches the state_o output of the aligner.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } fc_state_t;

    // IDLE must stay rotation-unique so that the hunt can only match on
    // the true frame boundary.
    localparam logic [FC_W-1:0] FC_IDLE     = 8'hF0;
    localparam logic [FC_W-1:0] FC_L1A      = 8'h2D;
    localparam logic [FC_W-1:0] FC_BCR      = 8'h4B;
    localparam logic [FC_W-1:0] FC_OCR      = 8'h55;
    localparam logic [FC_W-1:0] FC_CAL_REQ  = 8'h96;
    localparam logic [FC_W-1:0] FC_LINK_RST = 8'hA5;

endpackage

// File: rtl/fast_cmd_aligner_if.sv
// Serial-in / aligned-word-out bundle of the FAST_CMD aligner.
// master = bit source and command consumer, slave = the aligner.
interface fast_cmd_aligner_if;
    import fast_cmd_pkg::*;

    logic            din;
    logic            din_valid;
    logic [FC_W-1:0] cmd_data;
    logic            cmd_valid;
    logic            cmd_idle;

    modport master (
        output din, din_valid,
        input  cmd_data, cmd_valid, cmd_idle
    );

    modport slave (
        input  din, din_valid,
        output cmd_data, cmd_valid, cmd_idle
    );
endinterface

// File: rtl/fast_cmd_shreg.sv
// Serial-to-parallel shifter for the aligner: an 8-bit history of the
// incoming bits plus the in-frame bit counter that marks frame ends.
module fast_cmd_shreg
    import fast_cmd_pkg::*;
(
    input  logic            clk160,
    input  logic            rstb,
    input  logic            din,
    input  logic            din_valid,
    input  logic            cnt_en,     // count bits only once a boundary is assumed
    input  logic            cnt_clr,    // hold the counter at 0 (searching / relock)
    output logic [FC_W-1:0] sr_next,
    output logic            frame_evt
);
    logic [FC_W-1:0] sr_reg;
    logic [2:0]      bit_cnt_reg;

    assign sr_next   = {sr_reg[FC_W-2:0], din};
    assign frame_evt = din_valid && cnt_en && (bit_cnt_reg == 3'd7);

    // Shift in one bit per qualified strobe; keeps shifting regardless of state.
    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            sr_reg <= '0;
        end else if (din_valid) begin
            sr_reg <= sr_next;
        end
    end

    // Bit position inside the current frame; wraps naturally from 7 to 0.
    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            bit_cnt_reg <= 3'd0;
        end else if (cnt_clr) begin
            bit_cnt_reg <= 3'd0;
        end else if (din_valid && cnt_en) begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
    end
endmodule

// File: rtl/fast_cmd_aligner.sv
// FAST_CMD elink frame aligner: hunts for the IDLE code, verifies lock over
// LOCK_COUNT frames, then emits aligned command words until IDLE frames stop
// for IDLE_TIMEOUT frames. Optional unlock counter: FAST_CMD_ALIGN_ERRCNT_EN.
module fast_cmd_aligner
    import fast_cmd_pkg::*;
#(
    parameter logic [FC_W-1:0] IDLE_PATTERN = FC_IDLE,
    parameter int              LOCK_COUNT   = 4,
    parameter int              IDLE_TIMEOUT = 64
) (
    input  logic              clk160,
    input  logic              rstb,
    fast_cmd_aligner_if.slave fc,
    input  logic              relock,
    output logic              locked,
    output logic [1:0]        state_o
`ifdef FAST_CMD_ALIGN_ERRCNT_EN
    ,
    input  logic              unlock_cnt_clr,
    output logic [15:0]       unlock_cnt
`endif
);
    fc_state_t       state_reg;
    logic [3:0]      good_cnt_reg;
    logic [7:0]      miss_cnt_reg;
    logic [FC_W-1:0] cmd_data_reg;
    logic            cmd_valid_reg;
    logic            cmd_idle_reg;
    logic            locked_reg;

    logic [FC_W-1:0] sr_next;
    logic            frame_evt;
    logic            sr_is_idle;
    logic [3:0]      good_inc;
    logic [7:0]      miss_inc;
    logic            timeout_hit;

    fast_cmd_shreg u_shreg (
        .clk160    (clk160),
        .rstb      (rstb),
        .din       (fc.din),
        .din_valid (fc.din_valid),
        .cnt_en    (state_reg != SEARCH),
        .cnt_clr   (relock || (state_reg == SEARCH)),
        .sr_next   (sr_next),
        .frame_evt (frame_evt)
    );

    assign sr_is_idle  = (sr_next == IDLE_PATTERN);
    assign good_inc    = good_cnt_reg + 4'd1;
    assign miss_inc    = miss_cnt_reg + 8'd1;
    assign timeout_hit = frame_evt && !sr_is_idle && (miss_inc >= 8'(IDLE_TIMEOUT));

    assign fc.cmd_data  = cmd_data_reg;
    assign fc.cmd_valid = cmd_valid_reg;
    assign fc.cmd_idle  = cmd_idle_reg;
    assign locked       = locked_reg;
    assign state_o      = state_reg;

    // Alignment FSM with its counters and registered command outputs.
    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            state_reg     <= SEARCH;
            good_cnt_reg  <= 4'd0;
            miss_cnt_reg  <= 8'd0;
            cmd_data_reg  <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_idle_reg  <= 1'b0;
            locked_reg    <= 1'b0;
        end else begin
            cmd_valid_reg <= 1'b0;
            if (relock) begin
                // Relock beats any coincident match or frame event.
                state_reg    <= SEARCH;
                good_cnt_reg <= 4'd0;
                miss_cnt_reg <= 8'd0;
                locked_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    SEARCH: begin
                        if (fc.din_valid && sr_is_idle) begin
                            good_cnt_reg <= 4'd1;
                            miss_cnt_reg <= 8'd0;
                            if (LOCK_COUNT == 1) begin
                                state_reg  <= LOCKED;
                                locked_reg <= 1'b1;
                            end else begin
                                state_reg <= VERIFY;
                            end
                        end
                    end
                    VERIFY: begin
                        if (frame_evt) begin
                            if (sr_is_idle) begin
                                good_cnt_reg <= good_inc;
                                if (good_inc == 4'(LOCK_COUNT)) begin
                                    state_reg    <= LOCKED;
                                    locked_reg   <= 1'b1;
                                    miss_cnt_reg <= 8'd0;
                                end
                            end else begin
                                state_reg    <= SEARCH;
                                good_cnt_reg <= 4'd0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (frame_evt) begin
                            if (timeout_hit) begin
                                // The frame that exhausts the budget is not forwarded.
                                state_reg    <= SEARCH;
                                locked_reg   <= 1'b0;
                                good_cnt_reg <= 4'd0;
                                miss_cnt_reg <= 8'd0;
                            end else begin
                                miss_cnt_reg  <= sr_is_idle ? 8'd0 : miss_inc;
                                cmd_data_reg  <= sr_next;
                                cmd_valid_reg <= 1'b1;
                                cmd_idle_reg  <= sr_is_idle;
                            end
                        end
                    end
                    default: begin
                        state_reg  <= SEARCH;
                        locked_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FAST_CMD_ALIGN_ERRCNT_EN
    logic [15:0] unlock_cnt_reg;
    logic        unlock_evt;

    assign unlock_evt = (state_reg == LOCKED) && (relock || timeout_hit);
    assign unlock_cnt = unlock_cnt_reg;

    // Saturating count of lock losses; a clear request wins over an increment.
    always_ff @(posedge clk160 or negedge rstb) begin
        if (!rstb) begin
            unlock_cnt_reg <= 16'd0;
        end else if (unlock_cnt_clr) begin
            unlock_cnt_reg <= 16'd0;
        end else if (unlock_evt && (unlock_cnt_reg != 16'hFFFF)) begin
            unlock_cnt_reg <= unlock_cnt_reg + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fast_cmd_aligner.sv
// Directed bench for fast_cmd_aligner (default parameters: IDLE=F0,
// LOCK_COUNT=4, IDLE_TIMEOUT=64). Unlock counter checks are built when
// FAST_CMD_ALIGN_ERRCNT_EN is defined.
module tb_fast_cmd_aligner;
    logic       clk160 = 1'b0;
    logic       rstb;
    logic       relock;
    logic       locked;
    logic [1:0] state_o;
`ifdef FAST_CMD_ALIGN_ERRCNT_EN
    logic        unlock_cnt_clr;
    logic [15:0] unlock_cnt;
`endif

    int         total = 0;
    int         bad   = 0;
    int         pulses;
    int         sum;
    logic [7:0] last_data;
    logic       last_idle;

    fast_cmd_aligner_if fc ();

    fast_cmd_aligner dut (
        .clk160         (clk160),
        .rstb           (rstb),
        .fc             (fc),
        .relock         (relock),
        .locked         (locked),
        .state_o        (state_o)
`ifdef FAST_CMD_ALIGN_ERRCNT_EN
        ,
        .unlock_cnt_clr (unlock_cnt_clr),
        .unlock_cnt     (unlock_cnt)
`endif
    );

    always #5 clk160 = ~clk160;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Record any command pulse visible just after the last clock edge.
    task automatic grab();
        if (fc.cmd_valid === 1'b1) begin
            pulses++;
            last_data = fc.cmd_data;
            last_idle = fc.cmd_idle;
        end
    endtask

    // One valid bit; with gap, an extra invalid cycle carrying a decoy bit.
    task automatic send_bit(input logic b, input bit gap, input logic rl);
        @(negedge clk160);
        fc.din = b;
        fc.din_valid = 1'b1;
        relock = rl;
        @(posedge clk160);
        #1;
        relock = 1'b0;
        grab();
        if (gap) begin
            @(negedge clk160);
            fc.din = ~b;
            fc.din_valid = 1'b0;
            @(posedge clk160);
            #1;
            grab();
        end
        fc.din_valid = 1'b0;
    endtask

    // One frame MSB first; relock optionally rides on its last bit.
    task automatic send_byte(input logic [7:0] v, input bit gap, input bit rl_last);
        pulses = 0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i], gap, rl_last && (i == 0));
        end
    endtask

    // From reset: 3-bit offset, then IDLE frames until lock and first pulse.
    task automatic lock_seq(input bit gap);
        for (int i = 0; i < 3; i++) send_bit(1'b0, gap, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            send_byte(8'hF0, gap, 1'b0);
            check_val("verify_state", 16'(state_o), 16'd1);
            check_val("verify_nopulse", 16'(pulses), 16'd0);
            check_val("verify_unlocked", 16'(locked), 16'd0);
        end
        send_byte(8'hF0, gap, 1'b0);
        check_val("lock_locked", 16'(locked), 16'd1);
        check_val("lock_state", 16'(state_o), 16'd2);
        check_val("lock_nopulse", 16'(pulses), 16'd0);
        for (int k = 0; k < 2; k++) begin
            send_byte(8'hF0, gap, 1'b0);
            check_val("idle_pulse", 16'(pulses), 16'd1);
            check_val("idle_data", 16'(last_data), 16'hF0);
            check_val("idle_flag", 16'(last_idle), 16'd1);
        end
    endtask

    task automatic relock_from_search();
        for (int k = 0; k < 4; k++) send_byte(8'hF0, 1'b0, 1'b0);
        check_val("relock_locked", 16'(locked), 16'd1);
    endtask

    initial begin
        rstb = 1'b0;
        fc.din = 1'b0;
        fc.din_valid = 1'b0;
        relock = 1'b0;
`ifdef FAST_CMD_ALIGN_ERRCNT_EN
        unlock_cnt_clr = 1'b0;
`endif
        pulses = 0;
        repeat (3) @(posedge clk160);
        #1;
        check_val("rst_state", 16'(state_o), 16'd0);
        check_val("rst_locked", 16'(locked), 16'd0);
        check_val("rst_valid", 16'(fc.cmd_valid), 16'd0);
        check_val("rst_data", 16'(fc.cmd_data), 16'd0);
        check_val("rst_idle", 16'(fc.cmd_idle), 16'd0);
        @(negedge clk160);
        rstb = 1'b1;

        lock_seq(1'b0);

        // Single command while locked.
        send_byte(8'h96, 1'b0, 1'b0);
        check_val("cmd_pulse", 16'(pulses), 16'd1);
        check_val("cmd_data", 16'(last_data), 16'h96);
        check_val("cmd_idle", 16'(last_idle), 16'd0);
        check_val("cmd_locked", 16'(locked), 16'd1);
        send_byte(8'hF0, 1'b0, 1'b0);
        check_val("after_cmd_idle", 16'(last_idle), 16'd1);

        // 64 non-IDLE frames: 63 forwarded, then lock is lost.
        sum = 0;
        for (int k = 0; k < 64; k++) begin
            send_byte(8'h96, 1'b0, 1'b0);
            sum += pulses;
            if (k == 62) check_val("to_still_locked", 16'(locked), 16'd1);
        end
        check_val("to_pulses", 16'(sum), 16'd63);
        check_val("to_locked", 16'(locked), 16'd0);
        check_val("to_state", 16'(state_o), 16'd0);
`ifdef FAST_CMD_ALIGN_ERRCNT_EN
        check_val("unlock_to", unlock_cnt, 16'd1);
`endif
        relock_from_search();

        // Relock request with no traffic.
        @(negedge clk160);
        relock = 1'b1;
        @(posedge clk160);
        #1;
        relock = 1'b0;
        check_val("rl_locked", 16'(locked), 16'd0);
        check_val("rl_state", 16'(state_o), 16'd0);
        check_val("rl_valid", 16'(fc.cmd_valid), 16'd0);
`ifdef FAST_CMD_ALIGN_ERRCNT_EN
        check_val("unlock_rl", unlock_cnt, 16'd2);
`endif

        // Failed verify: IDLE then F1.
        send_byte(8'hF0, 1'b0, 1'b0);
        check_val("fv_state1", 16'(state_o), 16'd1);
        send_byte(8'hF1, 1'b0, 1'b0);
        check_val("fv_state0", 16'(state_o), 16'd0);
        check_val("fv_nopulse", 16'(pulses), 16'd0);
        check_val("fv_locked", 16'(locked), 16'd0);

        // Relock coincident with a frame event suppresses the pulse.
        relock_from_search();
        send_byte(8'hF0, 1'b0, 1'b1);
        check_val("rlf_nopulse", 16'(pulses), 16'd0);
        check_val("rlf_state", 16'(state_o), 16'd0);
`ifdef FAST_CMD_ALIGN_ERRCNT_EN
        check_val("unlock_rlf", unlock_cnt, 16'd3);
        @(negedge clk160);
        unlock_cnt_clr = 1'b1;
        @(posedge clk160);
        #1;
        unlock_cnt_clr = 1'b0;
        check_val("unlock_clr", unlock_cnt, 16'd0);
`endif

        // Async reset in the middle of a frame.
        relock_from_search();
        send_byte(8'hF0, 1'b0, 1'b0);
        check_val("pre_rst_pulse", 16'(pulses), 16'd1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        @(posedge clk160);
        #3;
        rstb = 1'b0;
        #1;
        check_val("arst_locked", 16'(locked), 16'd0);
        check_val("arst_state", 16'(state_o), 16'd0);
        check_val("arst_data", 16'(fc.cmd_data), 16'd0);
        check_val("arst_idle", 16'(fc.cmd_idle), 16'd0);
        check_val("arst_valid", 16'(fc.cmd_valid), 16'd0);
        repeat (2) @(posedge clk160);
        @(negedge clk160);
        rstb = 1'b1;

        // Same lock sequence with din_valid toggling.
        lock_seq(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
